mux_result_skid: RTL and testbench
==================================

// Module: mux_result_skid
// PURPOSE
//   Registered output stage placed directly after the 32-bit 2:1 result selector.
//   Captures the selected word c, tags it with zero/negative flags and hands it
//   downstream over a valid/ready handshake.
//   Two entries (main + skid) give full throughput with a registered in_ready,
//   so downstream back-pressure never forms a combinational path into the selector.
// PARAMETERS
//   WIDTH  32  data width; must match the selector output width
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_data    in   WIDTH  selected word (selector output c)
//   in_valid   in   1      in_data is meaningful this cycle
//   in_ready   out  1      stage accepts in_data this cycle (registered)
//   out_data   out  WIDTH  registered result word
//   out_zero   out  1      out_data == 0 (registered with data)
//   out_neg    out  1      out_data[WIDTH-1] (registered with data)
//   out_valid  out  1      out_data/flags valid
//   out_ready  in   1      downstream accepts this cycle
//   occupancy  out  2      entries held: 0, 1 or 2
// BEHAVIOUR
//   Reset (async, rst=1): state EMPTY; out_valid=0, in_ready=1, out_data=0,
//     out_zero=0, out_neg=0, occupancy=0; skid register cleared to 0.
//     Reset mid-transfer discards both entries; no partial beat survives.
//   Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   Flags are computed from the word as it is loaded into the main register:
//     out_zero = ~|word, out_neg = word[WIDTH-1]. They never change without out_data changing.
//   Latency: a word accepted at edge N is on out_data with out_valid=1 after edge N
//     (1 cycle) when the stage is EMPTY or drains that cycle.
//   State machine (occupancy mirrors state):
//     EMPTY (0): in_fire -> ONE, main<=in_data.
//     ONE   (1): in_fire & out_fire  -> ONE,   main<=in_data.
//                in_fire & ~out_fire -> FULL,  skid<=in_data, in_ready<=0.
//                ~in_fire & out_fire -> EMPTY, out_valid<=0.
//                neither             -> ONE, hold.
//     FULL  (2): in_ready=0, so in_fire cannot occur.
//                out_fire -> ONE, main<=skid, in_ready<=1.
//                else     -> hold.
//   out_valid = (state != EMPTY). in_ready = (state != FULL), driven from a flop.
//   Stability: while out_valid & ~out_ready, out_data/out_zero/out_neg are held.
//   Ordering: strictly FIFO. The skid word is always presented after the main word.
//   Data while in_valid=0 is ignored. in_data X with in_valid=0 must not corrupt state.
//   No combinational path from out_ready to in_ready or from in_* to out_*.
// TESTING
//   1 Reset then single beat 0x0000_0005, out_ready=1 -> next cycle out_data=5,
//     out_valid=1, zero=0, neg=0; following cycle out_valid=0, occupancy=0.
//   2 Stream 0x0,0x8000_0000,0x7FFF_FFFF back-to-back, out_ready=1 -> one per cycle,
//     flags (1,0),(0,1),(0,0), in_ready stays 1.
//   3 out_ready=0, send 0xA,0xB -> occupancy=2, in_ready=0, out_data=0xA held.
//     Raise out_ready -> 0xA then 0xB, in_ready back to 1.
//   4 FULL with out_ready=0 and in_valid=1 presenting 0xC for 3 cycles -> 0xC is not
//     accepted until in_ready=1. No word lost or duplicated (scoreboard).
//   5 Assert rst while occupancy=2 -> immediately out_valid=0, in_ready=1,
//     occupancy=0, out_data=0. Post-reset beat 0x1234 emerges alone.
//   6 Random in_valid/out_ready for 10k cycles -> output sequence equals input sequence;
//     flags match data on every fire.

Source files
------------

// File: rtl/mux_result_skid.sv
// mux_result_skid: registered two-entry (main + skid) output stage after the
// 32-bit result selector. The selected word is tagged with zero/negative flags
// and handed downstream over valid/ready. in_ready comes straight from a flop,
// so downstream back-pressure never reaches the selector combinationally.
// Ports:
//   clk, rst             clock, async active-high reset
//   in_data/in_valid     selector word and its valid
//   in_ready             registered accept
//   out_data/out_zero    registered word and its zero flag
//   out_neg/out_valid    sign flag and output valid
//   out_ready            downstream accept
//   occupancy            entries held (0..2)
module mux_result_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             in_ready_q, in_ready_d;

  logic             in_fire;
  logic             out_fire;
  logic             load_main;
  logic [WIDTH-1:0] load_word;

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    skid_d     = skid_q;
    in_ready_d = in_ready_q;
    load_main  = 1'b0;
    load_word  = in_data;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          // main is stalled: park the new word in skid and close the input
          state_d    = FULL;
          skid_d     = in_data;
          in_ready_d = 1'b0;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d    = ONE;
          load_main  = 1'b1;
          load_word  = skid_q;
          in_ready_d = 1'b1;
        end
      end
      default: begin
        state_d    = EMPTY;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // flags travel with the word so they only change when out_data does
  always_comb begin
    main_d = main_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    if (load_main) begin
      main_d = load_word;
      zero_d = ~|load_word;
      neg_d  = load_word[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign out_zero  = zero_q;
  assign out_neg   = neg_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_mux_result_skid.sv
// tb_mux_result_skid: directed vectors plus a randomized scoreboard run
// for the mux_result_skid output stage.
module tb_mux_result_skid;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_zero;
  logic        out_neg;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  occupancy;

  int n_checks;
  int n_fail;

  logic [31:0] sb_q[$];

  mux_result_skid #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] d,
                         input logic v, input logic z, input logic n,
                         input logic [1:0] occ, input logic rdy);
    check({tag, ".data"}, out_data, d);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, ".zero"}, {31'd0, out_zero}, {31'd0, z});
    check({tag, ".neg"}, {31'd0, out_neg}, {31'd0, n});
    check({tag, ".occ"}, {30'd0, occupancy}, {30'd0, occ});
    check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
  endtask

  initial begin
    logic [31:0] w;
    logic        pushed;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    chk_out("t1_reset", 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    rst = 1'b0;
    step();

    // 1: single beat
    in_valid  = 1'b1;
    in_data   = 32'h5;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = 'x;
    chk_out("t1_beat", 32'h5, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
    step();
    check("t1_drain.valid", {31'd0, out_valid}, 32'd0);
    check("t1_drain.occ", {30'd0, occupancy}, 32'd0);

    // 2: back-to-back stream
    in_valid = 1'b1;
    in_data  = 32'h0;
    step();
    chk_out("t2_w0", 32'h0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
    in_data = 32'h8000_0000;
    step();
    chk_out("t2_w1", 32'h8000_0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
    in_data = 32'h7FFF_FFFF;
    step();
    chk_out("t2_w2", 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
    in_valid = 1'b0;
    in_data  = 'x;
    step();
    check("t2_end.valid", {31'd0, out_valid}, 32'd0);

    // 3: fill under back-pressure, then drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_valid = 1'b0;
    in_data  = 'x;
    chk_out("t3_full", 32'hA, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    step();
    chk_out("t3_hold", 32'hA, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    out_ready = 1'b1;
    step();
    chk_out("t3_pop_a", 32'hB, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
    step();
    chk_out("t3_pop_b", 32'hB, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

    // 4: input held while FULL is not taken
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h10;
    step();
    in_data = 32'h11;
    step();
    in_data = 32'hC;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("t4_stall", 32'h10, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    end
    out_ready = 1'b1;
    step();
    chk_out("t4_skid", 32'h11, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
    step();
    in_valid = 1'b0;
    in_data  = 'x;
    chk_out("t4_c", 32'hC, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
    step();
    chk_out("t4_empty", 32'hC, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

    // 5: reset while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h8000_0001;
    step();
    in_data = 32'h0000_0022;
    step();
    in_valid = 1'b0;
    in_data  = 'x;
    check("t5_pre.occ", {30'd0, occupancy}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_out("t5_rst", 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h1234;
    step();
    in_valid = 1'b0;
    in_data  = 'x;
    chk_out("t5_beat", 32'h1234, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
    step();
    chk_out("t5_alone", 32'h1234, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

    // 6: random traffic against a FIFO scoreboard
    sb_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid = 1'($urandom_range(0, 1));
      if (in_valid)
        in_data = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      else
        in_data = 'x;
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      check("t6_occ", {30'd0, occupancy}, sb_q.size());
      pushed = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("t6_spurious", {31'd0, out_valid}, 32'd0);
        end else begin
          w = sb_q.pop_front();
          check("t6_data", out_data, w);
          check("t6_zero", {31'd0, out_zero}, {31'd0, (w == 32'h0)});
          check("t6_neg", {31'd0, out_neg}, {31'd0, w[31]});
        end
      end
      if (pushed) sb_q.push_back(in_data);
      step();
    end
    in_valid  = 1'b0;
    in_data   = 'x;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      if (out_valid) begin
        w = sb_q.pop_front();
        check("t6_drain", out_data, w);
      end
      step();
    end
    check("t6_left", sb_q.size(), 32'd0);
    @(negedge clk);
    check("t6_final.valid", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
